// File: rtl/axi_multiport_memory.sv
// Single-beat AXI subordinate memory: PORT_NB ports share one word array behind per-port AW/W/AR FIFOs.
// Define AXI_MULTIPORT_MEMORY_ADDR_CHECK_EN to answer out-of-range word indices with SLVERR.

module axi_multiport_memory_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         push_valid,
    input  logic [W-1:0] push_data,
    output logic         ready,
    input  logic         pop,
    output logic         not_empty,
    output logic [W-1:0] head
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  store [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push;

    // Ready looks only at registered occupancy, so a pop never makes room for a same-edge push.
    assign ready     = run && (count != (PW+1)'(DEPTH));
    assign not_empty = (count != '0);
    assign push      = push_valid && ready;
    assign head      = store[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_data;
    end
endmodule

module axi_multiport_memory_port #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int ID_W        = 8,
    parameter int WORDS       = 4096,
    parameter int QUEUE_DEPTH = 4,
    parameter int IDX_W       = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [ID_W-1:0]     awid,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [ID_W-1:0]     arid,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rvalid,
    input  logic                rready,
    output logic                mem_we,
    output logic [IDX_W-1:0]    mem_widx,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wstrb,
    output logic [IDX_W-1:0]    mem_ridx,
    input  logic [DATA_W-1:0]   mem_rdata
);
    localparam int OFF    = $clog2(DATA_W/8);
    localparam int STRB_W = DATA_W/8;

    logic [ADDR_W+ID_W-1:0]   aw_head, ar_head;
    logic [DATA_W+STRB_W-1:0] w_head;
    logic                     aw_ne, w_ne, ar_ne;
    logic                     wr_fire, rd_fire;
    logic                     wr_err, rd_err;
    logic [ADDR_W-1:0]        wr_word, rd_word;

    axi_multiport_memory_fifo #(.W(ADDR_W+ID_W), .DEPTH(QUEUE_DEPTH)) u_aw (
        .clk, .rst_n, .run,
        .push_valid(awvalid), .push_data({awid, awaddr}), .ready(awready),
        .pop(wr_fire), .not_empty(aw_ne), .head(aw_head)
    );

    axi_multiport_memory_fifo #(.W(DATA_W+STRB_W), .DEPTH(QUEUE_DEPTH)) u_w (
        .clk, .rst_n, .run,
        .push_valid(wvalid), .push_data({wstrb, wdata}), .ready(wready),
        .pop(wr_fire), .not_empty(w_ne), .head(w_head)
    );

    axi_multiport_memory_fifo #(.W(ADDR_W+ID_W), .DEPTH(QUEUE_DEPTH)) u_ar (
        .clk, .rst_n, .run,
        .push_valid(arvalid), .push_data({arid, araddr}), .ready(arready),
        .pop(rd_fire), .not_empty(ar_ne), .head(ar_head)
    );

    assign wr_word = aw_head[ADDR_W-1:0] >> OFF;
    assign rd_word = ar_head[ADDR_W-1:0] >> OFF;

`ifdef AXI_MULTIPORT_MEMORY_ADDR_CHECK_EN
    assign wr_err = (wr_word >= ADDR_W'(WORDS));
    assign rd_err = (rd_word >= ADDR_W'(WORDS));
`else
    // Without the check, the low index bits alias into the array.
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    assign wr_fire   = aw_ne && w_ne && (!bvalid || bready);
    assign rd_fire   = ar_ne && (!rvalid || rready);
    assign mem_we    = wr_fire && !wr_err;
    assign mem_widx  = wr_word[IDX_W-1:0];
    assign mem_wdata = w_head[DATA_W-1:0];
    assign mem_wstrb = w_head[DATA_W +: STRB_W];
    assign mem_ridx  = rd_word[IDX_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid <= 1'b0;
            bid    <= '0;
            bresp  <= '0;
        end else if (wr_fire) begin
            bvalid <= 1'b1;
            bid    <= aw_head[ADDR_W +: ID_W];
            bresp  <= wr_err ? 2'b10 : 2'b00;
        end else if (bready) begin
            bvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rid    <= '0;
            rdata  <= '0;
            rresp  <= '0;
        end else if (rd_fire) begin
            rvalid <= 1'b1;
            rid    <= ar_head[ADDR_W +: ID_W];
            rdata  <= rd_err ? '0 : mem_rdata;
            rresp  <= rd_err ? 2'b10 : 2'b00;
        end else if (rready) begin
            rvalid <= 1'b0;
        end
    end
endmodule

module axi_multiport_memory #(
    parameter int PORT_NB     = 4,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 64,
    parameter int ID_W        = 8,
    parameter int WORDS       = 4096,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [PORT_NB-1:0][ADDR_W-1:0]    i_axi_s_awaddr,
    input  logic [PORT_NB-1:0][ID_W-1:0]      i_axi_s_awid,
    input  logic [PORT_NB-1:0]                i_axi_s_awvalid,
    output logic [PORT_NB-1:0]                o_axi_s_awready,
    input  logic [PORT_NB-1:0][DATA_W-1:0]    i_axi_s_wdata,
    input  logic [PORT_NB-1:0][DATA_W/8-1:0]  i_axi_s_wstrb,
    input  logic [PORT_NB-1:0]                i_axi_s_wvalid,
    output logic [PORT_NB-1:0]                o_axi_s_wready,
    output logic [PORT_NB-1:0][ID_W-1:0]      o_axi_s_bid,
    output logic [PORT_NB-1:0][1:0]           o_axi_s_bresp,
    output logic [PORT_NB-1:0]                o_axi_s_bvalid,
    input  logic [PORT_NB-1:0]                i_axi_s_bready,
    input  logic [PORT_NB-1:0][ADDR_W-1:0]    i_axi_s_araddr,
    input  logic [PORT_NB-1:0][ID_W-1:0]      i_axi_s_arid,
    input  logic [PORT_NB-1:0]                i_axi_s_arvalid,
    output logic [PORT_NB-1:0]                o_axi_s_arready,
    output logic [PORT_NB-1:0][ID_W-1:0]      o_axi_s_rid,
    output logic [PORT_NB-1:0][DATA_W-1:0]    o_axi_s_rdata,
    output logic [PORT_NB-1:0][1:0]           o_axi_s_rresp,
    output logic [PORT_NB-1:0]                o_axi_s_rvalid,
    input  logic [PORT_NB-1:0]                i_axi_s_rready
);
    localparam int IDX_W  = $clog2(WORDS);
    localparam int STRB_W = DATA_W/8;

    logic [DATA_W-1:0]                mem [WORDS];
    logic                             run;
    logic [PORT_NB-1:0]               mem_we;
    logic [PORT_NB-1:0][IDX_W-1:0]    mem_widx, mem_ridx;
    logic [PORT_NB-1:0][DATA_W-1:0]   mem_wdata, mem_rdata;
    logic [PORT_NB-1:0][STRB_W-1:0]   mem_wstrb;

    // Readies stay low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) run <= 1'b0;
        else        run <= 1'b1;
    end

    for (genvar p = 0; p < PORT_NB; p++) begin : g_port
        assign mem_rdata[p] = mem[mem_ridx[p]];

        axi_multiport_memory_port #(
            .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .WORDS(WORDS),
            .QUEUE_DEPTH(QUEUE_DEPTH), .IDX_W(IDX_W)
        ) u_port (
            .clk, .rst_n, .run,
            .awaddr(i_axi_s_awaddr[p]), .awid(i_axi_s_awid[p]),
            .awvalid(i_axi_s_awvalid[p]), .awready(o_axi_s_awready[p]),
            .wdata(i_axi_s_wdata[p]), .wstrb(i_axi_s_wstrb[p]),
            .wvalid(i_axi_s_wvalid[p]), .wready(o_axi_s_wready[p]),
            .bid(o_axi_s_bid[p]), .bresp(o_axi_s_bresp[p]),
            .bvalid(o_axi_s_bvalid[p]), .bready(i_axi_s_bready[p]),
            .araddr(i_axi_s_araddr[p]), .arid(i_axi_s_arid[p]),
            .arvalid(i_axi_s_arvalid[p]), .arready(o_axi_s_arready[p]),
            .rid(o_axi_s_rid[p]), .rdata(o_axi_s_rdata[p]), .rresp(o_axi_s_rresp[p]),
            .rvalid(o_axi_s_rvalid[p]), .rready(i_axi_s_rready[p]),
            .mem_we(mem_we[p]), .mem_widx(mem_widx[p]), .mem_wdata(mem_wdata[p]),
            .mem_wstrb(mem_wstrb[p]), .mem_ridx(mem_ridx[p]), .mem_rdata(mem_rdata[p])
        );
    end

    // Later ports overwrite earlier ones per byte lane; reads above see the pre-edge word.
    always_ff @(posedge clk) begin
        for (int p = 0; p < PORT_NB; p++) begin
            if (mem_we[p]) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if (mem_wstrb[p][b]) mem[mem_widx[p]][b*8 +: 8] <= mem_wdata[p][b*8 +: 8];
                end
            end
        end
    end
endmodule
